oled_scanout: RTL and testbench

//  Reads the 64x32 1bpp CHIP-8 framebuffer (256 bytes at 0x100-0x1FF, row-major, 8 bytes/row,
//  MSB = leftmost pixel) that the cpu writes, and streams it to an SSD1306 128x64 OLED over SPI.

---
 rtl/oled_scanout_pkg.sv | 37 +++
 rtl/oled_scanout_if.sv | 29 ++
 rtl/oled_scanout_spi_byte_tx.sv | 76 +++++++
 rtl/oled_scanout.sv | 186 ++++++++++++++++++
 tb/tb_oled_scanout.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_scanout_pkg.sv
// Shared constants for the CHIP-8 framebuffer to SSD1306 OLED scanout: framebuffer geometry,
// SSD1306 addressing commands, FSM state encoding and the command ROM.
package oled_scanout_pkg;

    localparam logic [11:0] FB_BASE_DEFAULT = 12'h100;
    localparam int          FB_BYTES        = 256;
    localparam int          OLED_W          = 128;
    localparam int          OLED_PAGES      = 8;
    localparam int          N_CMD           = 6;
    localparam int          N_DATA          = OLED_W * OLED_PAGES;

    localparam logic [7:0] SET_COL_ADDR  = 8'h21;
    localparam logic [7:0] SET_PAGE_ADDR = 8'h22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Full-screen horizontal addressing window: columns 0..127, pages 0..7
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SET_COL_ADDR;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'(OLED_W - 1);
            3'd3:    b = SET_PAGE_ADDR;
            3'd4:    b = 8'h00;
            default: b = 8'(OLED_PAGES - 1);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_scanout_if.sv
// Bus bundle for oled_scanout: framebuffer read port (1-cycle read latency) and SPI link to the OLED.
interface oled_scanout_if;

    logic [11:0] mem_addr;
    logic [7:0]  mem_rd_data;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_dc;
    logic        spi_cs_n;

    modport master (
        output mem_addr,
        input  mem_rd_data,
        output spi_sck,
        output spi_mosi,
        output spi_dc,
        output spi_cs_n
    );

    modport slave (
        input  mem_addr,
        output mem_rd_data,
        input  spi_sck,
        input  spi_mosi,
        input  spi_dc,
        input  spi_cs_n
    );

endinterface

// File: rtl/oled_scanout_spi_byte_tx.sv
// SPI mode-0 byte transmitter: MSB first, CLK_DIV clocks per half-bit, sck low phase first.
// o_done pulses in the cycle after the last high phase; a new byte may be loaded in that same cycle.
module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_dc,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_dc
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             r_busy;
    logic             r_done;
    logic             r_sck;
    logic             r_dc;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit;
    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sck   <= 1'b0;
            r_dc    <= 1'b0;
            r_shift <= 8'h00;
            r_bit   <= 3'd0;
            r_div   <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_load) begin
                    r_busy  <= 1'b1;
                    r_shift <= i_byte;
                    r_dc    <= i_dc;
                    r_bit   <= 3'd0;
                    r_div   <= '0;
                    r_sck   <= 1'b0;
                end
            end else if (r_div == DIV_LAST) begin
                r_div <= '0;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                end else begin
                    // falling edge: advance mosi only while sck returns low
                    r_sck <= 1'b0;
                    if (r_bit == 3'd7) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {r_shift[6:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_ready = !r_busy;
    assign o_done  = r_done;
    assign o_sck   = r_sck;
    assign o_mosi  = r_shift[7];
    assign o_dc    = r_dc;

endmodule

// File: rtl/oled_scanout.sv
// Streams the 64x32 CHIP-8 framebuffer to an SSD1306 (128x64) over SPI with 2x2 pixel scaling.
// Build option: define OLED_SCANOUT_INVERT_EN to invert every data byte (commands untouched).
module oled_scanout
    import oled_scanout_pkg::*;
#(
    parameter int          CLK_DIV = 2,
    parameter logic [11:0] FB_BASE = FB_BASE_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    oled_scanout_if.master bus
);

    state_t      r_state;
    state_t      w_state_next;

    logic [10:0] r_k;
    logic [2:0]  r_fcnt;
    logic [2:0]  r_pix;
    logic [7:0]  r_byte;
    logic        r_last;
    logic [11:0] r_mem_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_cs_n;

    logic        w_tx_load;
    logic [7:0]  w_tx_byte;
    logic        w_tx_dc;
    logic        w_tx_ready;
    logic        w_tx_done;
    logic        w_sck;
    logic        w_mosi;
    logic        w_dc;

    logic        w_cur_bit;
    logic [3:0]  w_pix;
    logic [7:0]  w_scaled;
    logic [7:0]  w_data_byte;
    logic [11:0] w_row_addr;
    logic        w_k_last;
    logic        w_active_next;

    // Byte k: page k[9:7], fb column byte k[6:4], pixel bit 7-k[3:1]; fetch step picks the row in the page
    assign w_row_addr = FB_BASE + {4'h0, r_k[9:7], r_fcnt[1:0], r_k[6:4]};
    assign w_cur_bit  = bus.mem_rd_data[~r_k[3:1]];
    assign w_pix      = {w_cur_bit, r_pix};
    assign w_k_last   = (r_k == 11'(N_DATA - 1));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_scale
            assign w_scaled[2*gi +: 2] = {2{w_pix[gi]}};
        end
    endgenerate

`ifdef OLED_SCANOUT_INVERT_EN
    assign w_data_byte = ~w_scaled;
`else
    assign w_data_byte = w_scaled;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // SHIFT hands the prefetched byte to the transmitter, then fetches the next one while it shifts
    always_comb begin
        w_state_next = r_state;
        w_tx_load    = 1'b0;
        w_tx_byte    = 8'h00;
        w_tx_dc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_CMD;
            end
            ST_CMD: begin
                if (w_tx_ready) begin
                    w_tx_load = 1'b1;
                    w_tx_byte = cmd_byte(r_k[2:0]);
                    if (r_k == 11'(N_CMD - 1)) w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (r_fcnt == 3'd5) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_last) begin
                    if (w_tx_done) w_state_next = ST_DONE;
                end else if (w_tx_ready) begin
                    w_tx_load = 1'b1;
                    w_tx_byte = r_byte;
                    w_tx_dc   = 1'b1;
                    if (!w_k_last) w_state_next = ST_FETCH;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_active_next = (w_state_next == ST_CMD) || (w_state_next == ST_FETCH) ||
                           (w_state_next == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k        <= 11'd0;
            r_fcnt     <= 3'd0;
            r_pix      <= 3'd0;
            r_byte     <= 8'h00;
            r_last     <= 1'b0;
            r_mem_addr <= 12'h000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_busy <= w_active_next;
            r_done <= (w_state_next == ST_DONE);
            r_cs_n <= !w_active_next;
            case (r_state)
                ST_IDLE: begin
                    r_k    <= 11'd0;
                    r_fcnt <= 3'd0;
                    r_last <= 1'b0;
                end
                ST_CMD: begin
                    if (w_tx_ready) begin
                        if (r_k == 11'(N_CMD - 1)) r_k <= 11'd0;
                        else                       r_k <= r_k + 11'd1;
                    end
                end
                ST_FETCH: begin
                    // Four reads back to back; each row's data lands two steps after its address
                    if (r_fcnt < 3'd4) r_mem_addr <= w_row_addr;
                    if (r_fcnt >= 3'd2 && r_fcnt < 3'd5) r_pix <= {w_cur_bit, r_pix[2:1]};
                    if (r_fcnt == 3'd5) begin
                        r_byte <= w_data_byte;
                        r_fcnt <= 3'd0;
                    end else begin
                        r_fcnt <= r_fcnt + 3'd1;
                    end
                end
                ST_SHIFT: begin
                    if (!r_last && w_tx_ready) begin
                        if (w_k_last) r_last <= 1'b1;
                        else          r_k    <= r_k + 11'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .srst    (reset),
        .i_load  (w_tx_load),
        .i_byte  (w_tx_byte),
        .i_dc    (w_tx_dc),
        .o_ready (w_tx_ready),
        .o_done  (w_tx_done),
        .o_sck   (w_sck),
        .o_mosi  (w_mosi),
        .o_dc    (w_dc)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign bus.mem_addr = r_mem_addr;
    assign bus.spi_sck  = w_sck;
    assign bus.spi_mosi = w_mosi;
    assign bus.spi_dc   = w_dc;
    assign bus.spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_oled_scanout.sv
// Scoreboard bench for oled_scanout: expected SPI bytes are queued per frame, a monitor decodes
// SPI on sck rising edges and compares. Honours OLED_SCANOUT_INVERT_EN for expected data bytes.
module tb_oled_scanout;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    oled_scanout_if bus_if();

    oled_scanout #(
        .CLK_DIV (1),
        .FB_BASE (12'h100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [4096];
    always @(posedge clk) bus_if.mem_rd_data <= mem[bus_if.mem_addr];

`ifdef OLED_SCANOUT_INVERT_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    int         n_vec    = 0;
    int         n_err    = 0;
    int         rx_cnt   = 0;
    int         done_cnt = 0;
    int         addr_bad = 0;
    logic [8:0] exp_q [$];
    logic [7:0] exp_data [1024];

    // SPI decoder + scoreboard checker
    initial begin : monitor
        int         bit_cnt;
        logic       sck_prev;
        logic [7:0] rx_sh;
        logic       byte_dc;
        logic       dc_ok;
        logic [11:0] addr_prev;
        logic [8:0] exp_v;
        bit_cnt   = 0;
        sck_prev  = 1'b0;
        rx_sh     = 8'h00;
        byte_dc   = 1'b0;
        dc_ok     = 1'b1;
        addr_prev = 12'h000;
        forever begin
            @(negedge clk);
            if (!reset && bus_if.mem_addr != addr_prev &&
                (bus_if.mem_addr < 12'h100 || bus_if.mem_addr > 12'h1FF)) addr_bad++;
            addr_prev = bus_if.mem_addr;
            if (done) done_cnt++;
            if (bus_if.spi_cs_n) begin
                bit_cnt = 0;
            end else if (bus_if.spi_sck && !sck_prev) begin
                if (bit_cnt == 0) begin
                    byte_dc = bus_if.spi_dc;
                    dc_ok   = 1'b1;
                end else if (bus_if.spi_dc != byte_dc) begin
                    dc_ok = 1'b0;
                end
                rx_sh = {rx_sh[6:0], bus_if.spi_mosi};
                bit_cnt++;
                if (bit_cnt == 8) begin
                    bit_cnt = 0;
                    rx_cnt++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL spi_byte rx#%0d: got dc=%0b data=%02h, required no byte", rx_cnt, byte_dc, rx_sh);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if ({byte_dc, rx_sh} != exp_v || !dc_ok) begin
                            n_err++;
                            $display("FAIL spi_byte rx#%0d: got dc=%0b data=%02h dc_stable=%0b, required dc=%0b data=%02h",
                                     rx_cnt, byte_dc, rx_sh, dc_ok, exp_v[8], exp_v[7:0]);
                        end
                    end
                end
            end
            sck_prev = bus_if.spi_sck;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 1024; k++) exp_data[k] = 8'h00;
    endtask

    task automatic push_frame();
        logic [7:0] cmds [6];
        cmds = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, cmds[i]});
        for (int k = 0; k < 1024; k++) exp_q.push_back({1'b1, exp_data[k] ^ INV});
    endtask

    task automatic start_pulse(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " busy_after_start"}, 32'(busy), 32'd1);
        chk({name, " cs_n_after_start"}, 32'(bus_if.spi_cs_n), 32'd0);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int i;
        i = 0;
        while (rx_cnt < target && i < 30000) begin
            @(negedge clk);
            i++;
        end
        chk({name, " byte_count_reached"}, 32'(rx_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (!done && i < 30000) begin
            @(negedge clk);
            i++;
        end
        chk({name, " done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic full_frame(input string name, input bit restart_mid, input bit start_at_done);
        int rx0;
        int d0;
        rx0 = rx_cnt;
        d0  = done_cnt;
        push_frame();
        start_pulse(name);
        if (restart_mid) begin
            wait_bytes(rx0 + 100, name);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({name, " busy_after_restart"}, 32'(busy), 32'd1);
        end
        wait_done(name);
        if (start_at_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk({name, " bytes_in_frame"}, 32'(rx_cnt - rx0), 32'd1030);
        chk({name, " queue_drained"}, 32'(exp_q.size()), 32'd0);
        chk({name, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, " busy_after_done"}, 32'(busy), 32'd0);
        chk({name, " cs_n_after_done"}, 32'(bus_if.spi_cs_n), 32'd1);
        $display("frame %s: %0d bytes, %0d done pulses", name, rx_cnt - rx0, done_cnt - d0);
    endtask

    initial begin
        int rx0;
        int d0;
        int r1;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset busy",     32'(busy),            32'd0);
        chk("reset done",     32'(done),            32'd0);
        chk("reset mem_addr", 32'(bus_if.mem_addr), 32'd0);
        chk("reset sck",      32'(bus_if.spi_sck),  32'd0);
        chk("reset mosi",     32'(bus_if.spi_mosi), 32'd0);
        chk("reset dc",       32'(bus_if.spi_dc),   32'd0);
        chk("reset cs_n",     32'(bus_if.spi_cs_n), 32'd1);
        $display("reset: outputs checked");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // all-zero framebuffer, second start mid-frame must be ignored
        clear_exp();
        full_frame("zero_fb", 1'b1, 1'b0);

        // top-left pixel and bottom-right pixel; start coinciding with done is ignored
        mem[12'h100] = 8'h80;
        mem[12'h1FF] = 8'h01;
        clear_exp();
        exp_data[0]    = 8'h03;
        exp_data[1]    = 8'h03;
        exp_data[1022] = 8'hC0;
        exp_data[1023] = 8'hC0;
        full_frame("corners", 1'b0, 1'b1);

        // reset after 500 bytes abandons the frame without a done pulse
        rx0 = rx_cnt;
        d0  = done_cnt;
        push_frame();
        start_pulse("abort");
        wait_bytes(rx0 + 500, "abort");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        chk("abort cs_n_after_reset", 32'(bus_if.spi_cs_n), 32'd1);
        chk("abort busy_after_reset", 32'(busy),            32'd0);
        chk("abort sck_after_reset",  32'(bus_if.spi_sck),  32'd0);
        r1 = rx_cnt;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort no_done",     32'(done_cnt - d0), 32'd0);
        chk("abort no_more_rx",  32'(rx_cnt - r1),   32'd0);
        $display("frame abort: %0d bytes before reset", r1 - rx0);

        // full top row lit, bottom-right pixel kept
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 8'hFF;
        clear_exp();
        for (int k = 0; k < 128; k++) exp_data[k] = 8'h03;
        exp_data[1022] = 8'hC0;
        exp_data[1023] = 8'hC0;
        full_frame("row0", 1'b0, 1'b0);

        chk("mem_addr_range", 32'(addr_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
